n64_ctrl_sniffer_mc: RTL and testbench
======================================

N64_CTRL_SNIFFER_MC -- requirements
Module: n64_ctrl_sniffer_mc

Interface
REQ-001 SHALL have parameter NUM_CH, default 1, number of independent controller lines sniffed (1..4).
REQ-002 SHALL have parameter RESP_BITS, default 32, controller response length in bits excluding stop bit (8..32).
REQ-003 SHALL have parameter CNT_W, default 8, width of per-channel edge-interval counter.
REQ-004 SHALL have parameter CMD_ID, default 8'h01, the N64 command byte that qualifies a response.
REQ-005 SHALL have parameter IGR_FRAMES, default 1, consecutive matching frames required to trigger reset (1..15).
REQ-006 SHALL have parameter RST_CNT_W, default 20, width of the reset-drive counter.
REQ-007 SHALL have ports, in this order: CTRL_CLK in 1, sole clock; CTRL_RST in 1, reset; CTRL_i in NUM_CH, raw controller lines; ctrl_tack_i in NUM_CH, per-channel toggle acknowledge from CPU domain; ctrl_data_o out NUM_CH*RESP_BITS, latched responses, channel 0 in LSBs; ctrl_valid_o out NUM_CH, new-data flags; ctrl_ovr_o out NUM_CH, sticky overrun; ctrl_detected_o out NUM_CH, controller present; igr_en_i in 1, enables in-game reset; igr_combo_i in 16, button pattern; N64_nRST_drv_o out 1, 1 = drive N64 reset low.
REQ-008 SHALL use one clock, CTRL_CLK; reset CTRL_RST SHALL be asynchronous and active-high.

Function
REQ-009 Each CTRL_i bit SHALL pass a 3-stage history (reset 3'b111); falling edge = hist[2]&!hist[1], rising edge = !hist[2]&hist[1].
REQ-010 Per channel, counter SHALL clear on either edge, else increment, saturating at all-ones.
REQ-011 On rising edge, low_cnt SHALL capture counter; on falling edge, completed bit = (low_cnt < counter).
REQ-012 States per channel: IDLE, CMD, RESP; IDLE->CMD only on falling edge with counter saturated.
REQ-013 CMD: first 8 completed bits shift in MSB first; at next falling edge (N64 stop bit), byte == CMD_ID -> RESP, else -> IDLE.
REQ-014 RESP: completed bits shift in, first bit into bit 0 of the response word; after RESP_BITS bits, the next falling edge completes the frame -> IDLE.
REQ-015 Counter saturation in CMD or RESP SHALL abort to IDLE without output update; saturation in RESP-wait following CMD SHALL clear ctrl_detected_o.
REQ-016 Frame completion SHALL set ctrl_detected_o; one cycle later ctrl_data_o slice updates and ctrl_valid_o goes 1.
REQ-017 ctrl_tack_i SHALL be 2-FF synchronised; any toggle SHALL clear ctrl_valid_o and ctrl_ovr_o of that channel.
REQ-018 Frame completion while ctrl_valid_o=1 SHALL overwrite data and set ctrl_ovr_o.
REQ-019 Frame update and tack toggle in the same cycle: valid SHALL remain 1; ovr follows REQ-018.
REQ-020 Channels SHALL operate fully independently; simultaneous completions on several channels SHALL all be captured.

Reset
REQ-021 While CTRL_RST=1: states IDLE, counters 0, histories 3'b111, ctrl_data_o 0, ctrl_valid_o 0, ctrl_ovr_o 0, ctrl_detected_o 0, N64_nRST_drv_o 0, IGR frame counter 0.
REQ-022 Reset mid-frame SHALL discard the partial frame; first frame after release requires saturated idle first.

Configuration
REQ-023 Macro N64_CTRL_IGR_EN defined: channel 0 completed frames with igr_en_i=1 and response[15:0]==igr_combo_i increment a frame counter, non-match clears it; reaching IGR_FRAMES asserts N64_nRST_drv_o and loads counter all-ones.
REQ-024 With N64_CTRL_IGR_EN: counter decrements to 0, then N64_nRST_drv_o deasserts; a new trigger while active reloads counter.
REQ-025 Without N64_CTRL_IGR_EN: N64_nRST_drv_o constant 0, no IGR logic; igr_en_i, igr_combo_i ignored.

Verification
REQ-026 Idle high 300 cycles, command 0x01, response 32'h0000_8000 (NUM_CH=1) -> ctrl_data_o=32'h0000_8000, ctrl_valid_o=1 one cycle after final falling edge, ctrl_detected_o=1.
REQ-027 Command 0x00 then response -> no update, ctrl_valid_o stays 0.
REQ-028 Two frames without tack -> second data present, ctrl_ovr_o=1; single tack toggle -> valid=0, ovr=0.
REQ-029 NUM_CH=2, frames ending same cycle with 32'h1 and 32'h2 -> both slices correct, both valid.
REQ-030 N64_CTRL_IGR_EN, IGR_FRAMES=3, RST_CNT_W=4, combo 16'h3030 matched 3 frames -> drive=1 for 15 cycles after load, then 0; 2 matches then miss -> no drive.
REQ-031 CTRL_RST pulse mid-response -> all outputs 0; next complete frame captured correctly.

Source files
------------

// File: rtl/n64_ctrl_sniffer_mc.sv
// rtl/n64_ctrl_sniffer_mc.sv - multi-channel N64 controller response sniffer
// In-game reset logic is compiled in only with `define N64_CTRL_IGR_EN.
module n64_ctrl_sniffer_mc #(
  parameter int         NUM_CH     = 1,
  parameter int         RESP_BITS  = 32,
  parameter int         CNT_W      = 8,
  parameter logic [7:0] CMD_ID     = 8'h01,
  parameter int         IGR_FRAMES = 1,
  parameter int         RST_CNT_W  = 20
) (
  input  logic                        CTRL_CLK,
  input  logic                        CTRL_RST,
  input  logic [NUM_CH-1:0]           CTRL_i,
  input  logic [NUM_CH-1:0]           ctrl_tack_i,
  output logic [NUM_CH*RESP_BITS-1:0] ctrl_data_o,
  output logic [NUM_CH-1:0]           ctrl_valid_o,
  output logic [NUM_CH-1:0]           ctrl_ovr_o,
  output logic [NUM_CH-1:0]           ctrl_detected_o,
  input  logic                        igr_en_i,
  input  logic [15:0]                 igr_combo_i,
  output logic                        N64_nRST_drv_o
);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_RESP} state_t;

  localparam logic [5:0] RB6 = 6'(RESP_BITS);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [2:0]           hist;
    logic [2:0]           tack_sync;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     low_cnt;
    logic [5:0]           bit_cnt;
    logic [7:0]           cmd_sr;
    logic [RESP_BITS-1:0] resp_sr;
    logic [RESP_BITS-1:0] data_q;
    logic                 valid_q, ovr_q, det_q, done_q;
    state_t               state, state_nx;
    logic                 fall, rise, sat, bit_val, tack_tgl;
    logic                 shift_cmd, shift_resp, frame_done, lost;

    assign fall     = hist[2] & ~hist[1];
    assign rise     = ~hist[2] & hist[1];
    assign sat      = &cnt;
    // A bit is a 1 when its low phase was shorter than its high phase.
    assign bit_val  = low_cnt < cnt;
    assign tack_tgl = tack_sync[2] ^ tack_sync[1];

    always_ff @(posedge CTRL_CLK or posedge CTRL_RST) begin
      if (CTRL_RST) state <= S_IDLE;
      else          state <= state_nx;
    end

    always_comb begin
      state_nx = state;
      case (state)
        S_IDLE: if (fall && sat) state_nx = S_CMD;
        S_CMD: begin
          if (sat) state_nx = S_IDLE;
          else if (fall && bit_cnt == 6'd8) state_nx = (cmd_sr == CMD_ID) ? S_RESP : S_IDLE;
        end
        S_RESP: begin
          if (sat) state_nx = S_IDLE;
          else if (fall && bit_cnt == RB6) state_nx = S_IDLE;
        end
        default: state_nx = S_IDLE;
      endcase
    end

    always_comb begin
      shift_cmd  = 1'b0;
      shift_resp = 1'b0;
      frame_done = 1'b0;
      lost       = 1'b0;
      case (state)
        S_CMD: begin
          shift_cmd = !sat && fall && (bit_cnt < 6'd8);
          lost      = sat && (bit_cnt == 6'd8);
        end
        S_RESP: begin
          shift_resp = !sat && fall && (bit_cnt < RB6);
          frame_done = !sat && fall && (bit_cnt == RB6);
        end
        default: ;
      endcase
    end

    always_ff @(posedge CTRL_CLK or posedge CTRL_RST) begin
      if (CTRL_RST) begin
        hist      <= 3'b111;
        tack_sync <= 3'b000;
        cnt       <= '0;
        low_cnt   <= '0;
        bit_cnt   <= '0;
        cmd_sr    <= '0;
        resp_sr   <= '0;
        data_q    <= '0;
        valid_q   <= 1'b0;
        ovr_q     <= 1'b0;
        det_q     <= 1'b0;
        done_q    <= 1'b0;
      end else begin
        hist      <= {hist[1:0], CTRL_i[c]};
        tack_sync <= {tack_sync[1:0], ctrl_tack_i[c]};
        if (fall || rise) cnt <= '0;
        else if (!sat)    cnt <= cnt + 1'b1;
        if (rise) low_cnt <= cnt;
        if (state_nx != state)        bit_cnt <= '0;
        else if (shift_cmd || shift_resp) bit_cnt <= bit_cnt + 6'd1;
        if (shift_cmd)  cmd_sr  <= {cmd_sr[6:0], bit_val};
        if (shift_resp) resp_sr <= {bit_val, resp_sr[RESP_BITS-1:1]};
        done_q <= frame_done;
        if (frame_done) det_q <= 1'b1;
        else if (lost)  det_q <= 1'b0;
        // A landing frame wins over a same-cycle acknowledge.
        if (done_q) begin
          data_q  <= resp_sr;
          valid_q <= 1'b1;
          ovr_q   <= ovr_q | valid_q;
        end else if (tack_tgl) begin
          valid_q <= 1'b0;
          ovr_q   <= 1'b0;
        end
      end
    end

    assign ctrl_data_o[c*RESP_BITS +: RESP_BITS] = data_q;
    assign ctrl_valid_o[c]    = valid_q;
    assign ctrl_ovr_o[c]      = ovr_q;
    assign ctrl_detected_o[c] = det_q;
  end

`ifdef N64_CTRL_IGR_EN
  logic [3:0]           igr_frames;
  logic [RST_CNT_W-1:0] rst_cnt;
  logic [15:0]          igr_word;

  assign igr_word = 16'(g_ch[0].resp_sr);

  always_ff @(posedge CTRL_CLK or posedge CTRL_RST) begin
    if (CTRL_RST) begin
      igr_frames <= '0;
      rst_cnt    <= '0;
    end else begin
      if (rst_cnt != '0) rst_cnt <= rst_cnt - 1'b1;
      if (g_ch[0].done_q) begin
        if (igr_en_i && igr_word == igr_combo_i) begin
          if (({1'b0, igr_frames} + 5'd1) >= 5'(IGR_FRAMES)) begin
            igr_frames <= '0;
            rst_cnt    <= '1;
          end else begin
            igr_frames <= igr_frames + 4'd1;
          end
        end else begin
          igr_frames <= '0;
        end
      end
    end
  end

  assign N64_nRST_drv_o = |rst_cnt;
`else
  localparam int unused_cfg = IGR_FRAMES + RST_CNT_W;
  logic unused_igr;
  assign unused_igr     = ^{igr_en_i, igr_combo_i};
  assign N64_nRST_drv_o = 1'b0;
`endif

endmodule

// File: tb/tb_n64_ctrl_sniffer_mc.sv
// tb/tb_n64_ctrl_sniffer_mc.sv - directed bench for n64_ctrl_sniffer_mc
module tb_n64_ctrl_sniffer_mc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        line_a = 1'b1, tack_a = 1'b0;
  logic [1:0]  line_b = 2'b11, tack_b = 2'b00;
  logic        igr_en = 1'b0;
  logic [15:0] igr_combo = 16'h3030;
  logic [31:0] data_a;
  logic        valid_a, ovr_a, det_a, drv_a;
  logic [63:0] data_b;
  logic [1:0]  valid_b, ovr_b, det_b;
  logic        drv_b;

  int checks = 0, errors = 0;
  int drv_cycles = 0;

`ifdef N64_CTRL_IGR_EN
  localparam int EXP_DRV = 15;
`else
  localparam int EXP_DRV = 0;
`endif

  n64_ctrl_sniffer_mc #(.IGR_FRAMES(3), .RST_CNT_W(4)) dut_a (
    .CTRL_CLK(clk), .CTRL_RST(rst), .CTRL_i(line_a), .ctrl_tack_i(tack_a),
    .ctrl_data_o(data_a), .ctrl_valid_o(valid_a), .ctrl_ovr_o(ovr_a),
    .ctrl_detected_o(det_a), .igr_en_i(igr_en), .igr_combo_i(igr_combo),
    .N64_nRST_drv_o(drv_a)
  );

  n64_ctrl_sniffer_mc #(.NUM_CH(2)) dut_b (
    .CTRL_CLK(clk), .CTRL_RST(rst), .CTRL_i(line_b), .ctrl_tack_i(tack_b),
    .ctrl_data_o(data_b), .ctrl_valid_o(valid_b), .ctrl_ovr_o(ovr_b),
    .ctrl_detected_o(det_b), .igr_en_i(1'b0), .igr_combo_i(igr_combo),
    .N64_nRST_drv_o(drv_b)
  );

  always @(negedge clk) if (drv_a) drv_cycles++;

  typedef struct {
    int          kind;  // 0 tack, 1 frame, 2 command only, 3 frame with coincident tack
    logic [7:0]  cmd;
    logic [31:0] resp;
    logic [31:0] e_data;
    logic        e_valid, e_ovr, e_det;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  // Cell k: command MSB first, console stop, response LSB first, controller stop.
  function automatic logic [41:0] mk_cells(input logic [7:0] cmd, input logic [31:0] resp);
    logic [41:0] c;
    for (int k = 0; k < 8; k++) c[k] = cmd[7-k];
    c[8] = 1'b1;
    for (int k = 0; k < 32; k++) c[9+k] = resp[k];
    c[41] = 1'b1;
    return c;
  endfunction

  task automatic idle(input int n);
    line_a = 1'b1;
    line_b = 2'b11;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [41:0] ca, input logic [41:0] cb, input int ncells,
                      input bit fin, input bit on_b, input bit tk);
    for (int k = 0; k < ncells; k++)
      for (int t = 0; t < 8; t++) begin
        @(negedge clk);
        if (on_b) line_b = {(t >= (cb[k] ? 2 : 6)), (t >= (ca[k] ? 2 : 6))};
        else      line_a = (t >= (ca[k] ? 2 : 6));
      end
    @(negedge clk);
    if (fin) begin
      line_a = 1'b0;
      line_b = 2'b00;
      @(negedge clk);
      if (tk) tack_a = ~tack_a;
      @(negedge clk);
    end
    line_a = 1'b1;
    line_b = 2'b11;
  endtask

  task automatic frame_a(input logic [7:0] cmd, input logic [31:0] resp);
    idle(300);
    send(mk_cells(cmd, resp), '0, 42, 1'b1, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual running required finished");
    $fatal(1);
  end

  initial begin
    int n, c0;
    vecs[0] = '{0, 8'h00, 32'h0,         32'h0000_8000, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{1, 8'h00, 32'h1234_5678, 32'h0000_8000, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{1, 8'h01, 32'hA5A5_0F0F, 32'hA5A5_0F0F, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{1, 8'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{0, 8'h00, 32'h0,         32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{2, 8'h01, 32'h0,         32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1, 8'h01, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{3, 8'h01, 32'h0000_0001, 32'h0000_0001, 1'b1, 1'b1, 1'b1};
    vecs[8] = '{0, 8'h00, 32'h0,         32'h0000_0001, 1'b0, 1'b0, 1'b1};

    repeat (3) @(negedge clk);
    chk("rst_data_a", 64'(data_a), 64'h0);
    chk("rst_flags_a", 64'({valid_a, ovr_a, det_a, drv_a}), 64'h0);
    chk("rst_data_b", data_b, 64'h0);
    chk("rst_flags_b", 64'({valid_b, ovr_b, det_b}), 64'h0);
    rst = 1'b0;

    // First frame: detected rises one cycle before data/valid.
    idle(300);
    send(mk_cells(8'h01, 32'h0000_8000), '0, 42, 1'b1, 1'b0, 1'b0);
    n = 0;
    while (!det_a && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("first_det", 64'(det_a), 64'h1);
    chk("first_valid_lag", 64'(valid_a), 64'h0);
    @(negedge clk);
    chk("first_valid", 64'(valid_a), 64'h1);
    chk("first_data", 64'(data_a), 64'h0000_8000);
    chk("first_ovr", 64'(ovr_a), 64'h0);

    for (int i = 0; i < 9; i++) begin
      case (vecs[i].kind)
        0: begin
          tack_a = ~tack_a;
          repeat (6) @(negedge clk);
        end
        2: begin
          idle(300);
          send(mk_cells(vecs[i].cmd, vecs[i].resp), '0, 9, 1'b0, 1'b0, 1'b0);
          idle(300);
        end
        default: begin
          idle(300);
          send(mk_cells(vecs[i].cmd, vecs[i].resp), '0, 42, 1'b1, 1'b0, vecs[i].kind == 3);
          repeat (10) @(negedge clk);
        end
      endcase
      chk($sformatf("v%0d_data", i), 64'(data_a), 64'(vecs[i].e_data));
      chk($sformatf("v%0d_valid", i), 64'(valid_a), 64'(vecs[i].e_valid));
      chk($sformatf("v%0d_ovr", i), 64'(ovr_a), 64'(vecs[i].e_ovr));
      chk($sformatf("v%0d_det", i), 64'(det_a), 64'(vecs[i].e_det));
    end

    // Two channels finishing on the same cycle.
    idle(300);
    send(mk_cells(8'h01, 32'h1), mk_cells(8'h01, 32'h2), 42, 1'b1, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    chk("dual_data", data_b, {32'h2, 32'h1});
    chk("dual_valid", 64'(valid_b), 64'h3);
    chk("dual_ovr", 64'(ovr_b), 64'h0);
    chk("dual_det", 64'(det_b), 64'h3);
    tack_b[1] = 1'b1;
    repeat (6) @(negedge clk);
    chk("dual_tack1_valid", 64'(valid_b), 64'h1);
    chk("dual_tack1_ovr", 64'(ovr_b), 64'h0);

    // In-game reset: two matches then a miss must not fire; three matches must.
    igr_en = 1'b1;
    #1 c0 = drv_cycles;
    frame_a(8'h01, 32'h0000_3030);
    frame_a(8'h01, 32'h0000_3030);
    frame_a(8'h01, 32'h0000_3031);
    #1 chk("igr_miss_drive", 64'(drv_cycles - c0), 64'h0);
    c0 = drv_cycles;
    frame_a(8'h01, 32'h0000_3030);
    frame_a(8'h01, 32'h0000_3030);
    frame_a(8'h01, 32'h0000_3030);
    repeat (40) @(negedge clk);
    #1 chk("igr_drive_cycles", 64'(drv_cycles - c0), 64'(EXP_DRV));
    chk("igr_drive_end", 64'(drv_a), 64'h0);
    igr_en = 1'b0;

    // Reset pulse in the middle of a response.
    fork
      begin
        idle(300);
        send(mk_cells(8'h01, 32'h5555_AAAA), '0, 42, 1'b1, 1'b0, 1'b0);
      end
      begin
        repeat (500) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_data_a", 64'(data_a), 64'h0);
        chk("midrst_flags_a", 64'({valid_a, ovr_a, det_a, drv_a}), 64'h0);
        chk("midrst_data_b", data_b, 64'h0);
        chk("midrst_flags_b", 64'({valid_b, ovr_b, det_b}), 64'h0);
        rst = 1'b0;
      end
    join
    repeat (10) @(negedge clk);
    chk("midrst_discard_valid", 64'(valid_a), 64'h0);
    chk("midrst_discard_data", 64'(data_a), 64'h0);
    frame_a(8'h01, 32'hDEAD_BEEF);
    chk("post_rst_data", 64'(data_a), 64'hDEAD_BEEF);
    chk("post_rst_flags", 64'({valid_a, ovr_a, det_a}), 64'h5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
